// File: rtl/mu_stream_pkg.sv
// Shared types and width helpers for the mu_stream width converters (downsize, later upsize).
package mu_stream_pkg;

    typedef enum logic {
        StEmpty = 1'b0,
        StHold  = 1'b1
    } ds_state_e;

    function automatic int unsigned stream_ratio(input int unsigned wide_w,
                                                 input int unsigned narrow_w);
        return (narrow_w == 0) ? 0 : wide_w / narrow_w;
    endfunction

    function automatic int unsigned stream_cnt_width(input int unsigned wide_w,
                                                     input int unsigned narrow_w);
        int unsigned r;
        r = stream_ratio(wide_w, narrow_w);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    // Legal only when the wide side splits into at least two whole narrow slices.
    function automatic bit stream_widths_legal(input int unsigned wide_w,
                                               input int unsigned narrow_w);
        return (narrow_w != 0) && ((wide_w % narrow_w) == 0) && ((wide_w / narrow_w) >= 2);
    endfunction

endpackage

// File: rtl/mu_stream_downsize_if.sv
// Handshake bundle of mu_stream_downsize: wide word in, narrow slice out.
// master = surrounding logic driving the block, slave = the downsizer itself.
interface mu_stream_downsize_if #(
    parameter int unsigned IW = 64,
    parameter int unsigned OW = 16
);
    logic [IW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );
endinterface

// File: rtl/mu_fifo_sync.sv
// Synchronous show-ahead FIFO with valid/ready on both ports; feeds mu_stream_downsize.
module mu_fifo_sync #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          not_full, not_empty, wr_en, rd_en;

    always_comb begin
        not_full  = (count_q != FULL_CNT);
        not_empty = (count_q != '0);
        wr_en     = wr_valid && not_full;
        rd_en     = rd_ready && not_empty;
        wr_ready  = not_full;
        rd_valid  = not_empty;
        rd_data   = mem_q[rptr_q];
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en) begin
            wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + AW'(1);
        end
        if (rd_en) begin
            rptr_d = (rptr_q == LAST_IDX) ? '0 : rptr_q + AW'(1);
        end
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wr_data;
        end
    end
endmodule

// File: rtl/mu_stream_downsize.sv
// Serialises IW-bit words into IW/OW consecutive OW-bit slices, LSB-first, zero-bubble reload.
// Define MU_DOWNSIZE_MSB_FIRST_EN to emit slices MSB-first instead.
module mu_stream_downsize
    import mu_stream_pkg::*;
#(
    parameter int unsigned IW = 64,
    parameter int unsigned OW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mu_stream_downsize_if.slave bus
);
    localparam int unsigned RATIO = stream_ratio(IW, OW);
    localparam int unsigned CW    = stream_cnt_width(IW, OW);
    localparam logic [CW-1:0] LAST_CNT = CW'(RATIO - 1);

    if (!stream_widths_legal(IW, OW)) begin : g_illegal_widths
        $error("mu_stream_downsize: IW must be a whole multiple of OW with IW/OW >= 2");
    end

    ds_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] sreg_q, sreg_d;
    logic          full, last, acc_in, acc_out;

    // in_ready reaches back through out_ready so a finishing word can be replaced same cycle.
    always_comb begin
        full          = (state_q == StHold);
        last          = full && (cnt_q == LAST_CNT);
        acc_out       = full && bus.out_ready;
        acc_in        = bus.in_valid && (!full || (bus.out_ready && last));
        bus.out_valid = full;
        bus.busy      = full;
        bus.out_last  = last;
        bus.in_ready  = !full || (bus.out_ready && last);
`ifdef MU_DOWNSIZE_MSB_FIRST_EN
        bus.out_data  = sreg_q[IW-1 -: OW];
`else
        bus.out_data  = sreg_q[OW-1:0];
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        unique case (state_q)
            StEmpty: begin
                if (acc_in) begin
                    sreg_d  = bus.in_data;
                    cnt_d   = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (acc_out) begin
                    if (last) begin
                        cnt_d = '0;
                        if (acc_in) begin
                            sreg_d = bus.in_data;
                        end else begin
                            state_d = StEmpty;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
`ifdef MU_DOWNSIZE_MSB_FIRST_EN
                        sreg_d = sreg_q << OW;
`else
                        sreg_d = sreg_q >> OW;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Holding register needs no reset: it is only observed while state_q is StHold.
    always_ff @(posedge clk) begin
        sreg_q <= sreg_d;
    end
endmodule
